// File: rtl/clock_pkg.sv
// Shared types, digit limits and BCD step helper for the HH:MM:SS time base.
// Pure declarations; no state, no latency, no flow control.
// Imported by bcd2_counter and bcd_time_counter.
package clock_pkg;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t SEC_MAX    = 8'h59;
    localparam bcd2_t MIN_MAX    = 8'h59;
    localparam bcd2_t HOUR_MAX24 = 8'h23;
    localparam bcd2_t HOUR_MIN12 = 8'h01;
    localparam bcd2_t HOUR_MAX12 = 8'h12;

    function automatic int div_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    // One BCD increment within [lo, hi]; hi wraps to lo, ones 9 carries into tens.
    function automatic bcd2_t bcd2_step(input bcd2_t v, input bcd2_t lo, input bcd2_t hi);
        if (v == hi)
            return lo;
        if (v[3:0] == 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        return {v[7:4], v[3:0] + 4'h1};
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit packed-BCD counter over [MIN, MAX], +1 / +2 / clear per cycle.
// Value registered, one cycle after inc/inc2/clr; carry is combinational.
// No backpressure: every request is taken in the cycle it is presented.
module bcd2_counter
    import clock_pkg::*;
#(
    parameter bcd2_t MAX = 8'h59,
    parameter bcd2_t MIN = 8'h00,
    parameter bcd2_t RST = MIN
) (
    input  logic        selfClk,
    input  logic        reset,
    input  logic        inc,
    input  logic        inc2,
    input  logic        clr,
    output logic [7:0]  value,
    output logic        carry
);

    bcd2_t one_up;
    bcd2_t two_up;
    bcd2_t nxt;

    always_comb begin
        one_up = bcd2_step(value, MIN, MAX);
        two_up = bcd2_step(one_up, MIN, MAX);
        nxt    = value;
        if (clr)
            nxt = MIN;
        else if (inc2)
            nxt = two_up;
        else if (inc)
            nxt = one_up;
    end

    // Carry flags the first step crossing MAX, so callers can tell whose step wrapped.
    assign carry = !clr && (inc || inc2) && (value == MAX);

    always_ff @(posedge selfClk or posedge reset) begin
        if (reset)
            value <= RST;
        else
            value <= nxt;
    end

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS packed-BCD time base with prescaler and synchronised adjust/clear; HOUR12_EN selects 12h mode.
// Latency: outputs update 1 cycle after tick; async adjust/clear act 3 cycles after their rising edge.
// No backpressure: every tick and detected edge is applied immediately.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic        selfClk,
    input  logic        reset,
    input  logic        run,
    input  logic        min_adv,
    input  logic        hour_adv,
    input  logic        sec_clr,
    output logic [7:0]  sec_bcd,
    output logic [7:0]  min_bcd,
    output logic [7:0]  hour_bcd,
    output logic        sec_pulse,
    output logic        min_wrap,
    output logic        pm
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = div_width(DIV);
    localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 1);

    logic [2:0]    min_sync;
    logic [2:0]    hour_sync;
    logic [2:0]    clr_sync;
    logic          min_edge;
    logic          hour_edge;
    logic          clr_edge;
    logic [CW-1:0] pre_cnt;
    logic          tick;
    logic          sec_tick;
    logic          sec_carry;
    logic          min_carry;
    logic          hour_carry;
    logic          hour_inc;
    logic          hour_inc2;
    logic          hour_wrap;

    // [0],[1] form the synchroniser, [2] holds the previous level for edge detect.
    always_ff @(posedge selfClk or posedge reset) begin
        if (reset) begin
            min_sync  <= 3'b000;
            hour_sync <= 3'b000;
            clr_sync  <= 3'b000;
        end else begin
            min_sync  <= {min_sync[1:0], min_adv};
            hour_sync <= {hour_sync[1:0], hour_adv};
            clr_sync  <= {clr_sync[1:0], sec_clr};
        end
    end

    assign min_edge  = min_sync[1]  & ~min_sync[2];
    assign hour_edge = hour_sync[1] & ~hour_sync[2];
    assign clr_edge  = clr_sync[1]  & ~clr_sync[2];

    assign tick     = run && (pre_cnt == PRE_LAST);
    assign sec_tick = tick && !clr_edge;

    always_ff @(posedge selfClk or posedge reset) begin
        if (reset)
            pre_cnt <= '0;
        else if (clr_edge)
            pre_cnt <= '0;
        else if (run)
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end

    bcd2_counter #(.MAX(SEC_MAX), .MIN(8'h00)) u_sec (
        .selfClk (selfClk),
        .reset   (reset),
        .inc     (sec_tick),
        .inc2    (1'b0),
        .clr     (clr_edge),
        .value   (sec_bcd),
        .carry   (sec_carry)
    );

    // With a coincident adjust the tick's step is applied first, so min_carry
    // gated by sec_carry means the tick itself crossed 59.
    bcd2_counter #(.MAX(MIN_MAX), .MIN(8'h00)) u_min (
        .selfClk (selfClk),
        .reset   (reset),
        .inc     (sec_carry ^ min_edge),
        .inc2    (sec_carry & min_edge),
        .clr     (1'b0),
        .value   (min_bcd),
        .carry   (min_carry)
    );

    assign hour_carry = min_carry & sec_carry;
    assign hour_inc   = hour_carry ^ hour_edge;
    assign hour_inc2  = hour_carry & hour_edge;

`ifdef HOUR12_EN
    bcd2_counter #(.MAX(HOUR_MAX12), .MIN(HOUR_MIN12), .RST(HOUR_MAX12)) u_hour (
        .selfClk (selfClk),
        .reset   (reset),
        .inc     (hour_inc),
        .inc2    (hour_inc2),
        .clr     (1'b0),
        .value   (hour_bcd),
        .carry   (hour_wrap)
    );

    // Toggle whenever this cycle's advance passes through 12.
    always_ff @(posedge selfClk or posedge reset) begin
        if (reset)
            pm <= 1'b0;
        else if ((hour_inc  && hour_bcd == 8'h11) ||
                 (hour_inc2 && (hour_bcd == 8'h10 || hour_bcd == 8'h11)))
            pm <= ~pm;
    end
`else
    bcd2_counter #(.MAX(HOUR_MAX24), .MIN(8'h00)) u_hour (
        .selfClk (selfClk),
        .reset   (reset),
        .inc     (hour_inc),
        .inc2    (hour_inc2),
        .clr     (1'b0),
        .value   (hour_bcd),
        .carry   (hour_wrap)
    );

    assign pm = 1'b0;
`endif

    always_ff @(posedge selfClk or posedge reset) begin
        if (reset) begin
            sec_pulse <= 1'b0;
            min_wrap  <= 1'b0;
        end else begin
            sec_pulse <= sec_tick;
            min_wrap  <= hour_carry;
        end
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter at CLK_HZ=4 (DIV=4): per-cycle model compare plus directed literal checks.
// Build with HOUR12_EN defined to exercise the 12-hour scenario.
module tb_bcd_time_counter;

    localparam int DIV = 4;
`ifdef HOUR12_EN
    localparam bit H12 = 1'b1;
`else
    localparam bit H12 = 1'b0;
`endif

    logic       selfClk  = 1'b0;
    logic       reset    = 1'b0;
    logic       run      = 1'b0;
    logic       min_adv  = 1'b0;
    logic       hour_adv = 1'b0;
    logic       sec_clr  = 1'b0;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hour_bcd;
    logic       sec_pulse;
    logic       min_wrap;
    logic       pm;

    int tests = 0;
    int fails = 0;
    int n_sp  = 0;
    int n_mw  = 0;
    bit chk_en = 1'b0;

    bcd_time_counter #(.CLK_HZ(4), .TICK_HZ(1)) dut (
        .selfClk   (selfClk),
        .reset     (reset),
        .run       (run),
        .min_adv   (min_adv),
        .hour_adv  (hour_adv),
        .sec_clr   (sec_clr),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .hour_bcd  (hour_bcd),
        .sec_pulse (sec_pulse),
        .min_wrap  (min_wrap),
        .pm        (pm)
    );

    always #5 selfClk = ~selfClk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    // Time held as plain integers; async inputs seen two samples late, acted on at a 0->1 step.
    int m_sec, m_min, m_hour, m_pre;
    bit m_pm, m_spulse, m_mwrap;
    bit [2:0] h_min, h_hour, h_clr;

    always @(posedge selfClk or posedge reset) begin : model
        bit e_min, e_hour, e_clr, tick;
        int s_wrap, h_carry, hadd;
        if (reset) begin
            m_sec = 0; m_min = 0; m_hour = H12 ? 12 : 0; m_pre = 0;
            m_pm = 0; m_spulse = 0; m_mwrap = 0;
            h_min = 0; h_hour = 0; h_clr = 0;
        end else begin
            e_min  = h_min[1]  && !h_min[2];
            e_hour = h_hour[1] && !h_hour[2];
            e_clr  = h_clr[1]  && !h_clr[2];
            h_min  = {h_min[1:0], min_adv};
            h_hour = {h_hour[1:0], hour_adv};
            h_clr  = {h_clr[1:0], sec_clr};
            tick   = run && (m_pre == DIV - 1);
            s_wrap = 0;
            m_spulse = 0;
            if (e_clr) begin
                m_sec = 0;
                m_pre = 0;
            end else begin
                if (run) m_pre = (m_pre + 1) % DIV;
                if (tick) begin
                    s_wrap = (m_sec == 59) ? 1 : 0;
                    m_sec = (m_sec + 1) % 60;
                    m_spulse = 1;
                end
            end
            h_carry = (s_wrap == 1 && m_min == 59) ? 1 : 0;
            m_min = (m_min + s_wrap + (e_min ? 1 : 0)) % 60;
            hadd = h_carry + (e_hour ? 1 : 0);
            for (int i = 0; i < hadd; i++) begin
                if (H12) begin
                    m_hour = m_hour % 12 + 1;
                    if (m_hour == 12) m_pm = !m_pm;
                end else begin
                    m_hour = (m_hour + 1) % 24;
                end
            end
            m_mwrap = (h_carry == 1);
        end
    end

    always @(negedge selfClk) begin
        if (chk_en) begin
            tests++;
            if (sec_bcd !== to_bcd(m_sec) || min_bcd !== to_bcd(m_min) ||
                hour_bcd !== to_bcd(m_hour) || sec_pulse !== m_spulse ||
                min_wrap !== m_mwrap || pm !== m_pm) begin
                fails++;
                $display("FAIL model_cycle t=%0t: dut %h:%h:%h sp=%b mw=%b pm=%b, expected %h:%h:%h sp=%b mw=%b pm=%b",
                         $time, hour_bcd, min_bcd, sec_bcd, sec_pulse, min_wrap, pm,
                         to_bcd(m_hour), to_bcd(m_min), to_bcd(m_sec), m_spulse, m_mwrap, m_pm);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge selfClk);
            #2;
            n_sp += int'(sec_pulse);
            n_mw += int'(min_wrap);
        end
    endtask

    task automatic do_reset(input logic r);
        @(posedge selfClk);
        #2;
        reset = 1'b1; run = r; min_adv = 1'b0; hour_adv = 1'b0; sec_clr = 1'b0;
        step(1);
        reset = 1'b0;
        n_sp = 0;
        n_mw = 0;
    endtask

    task automatic pulse_min(input int n);
        for (int i = 0; i < n; i++) begin
            min_adv = 1'b1; step(2);
            min_adv = 1'b0; step(2);
        end
        step(2);
    endtask

    task automatic pulse_hour(input int n);
        for (int i = 0; i < n; i++) begin
            hour_adv = 1'b1; step(2);
            hour_adv = 1'b0; step(2);
        end
        step(2);
    endtask

    initial begin
        // 1: reset, first second
        do_reset(1'b1);
        chk_en = 1'b1;
        check("t1_rst_sec", sec_bcd, 8'h00);
        check("t1_rst_hour", hour_bcd, H12 ? 8'h12 : 8'h00);
        check("t1_rst_pm", {7'd0, pm}, 8'h00);
        step(4);
        check("t1_sec", sec_bcd, 8'h01);
        check("t1_pulses", 8'(n_sp), 8'd1);
        check("t1_min", min_bcd, 8'h00);

`ifndef HOUR12_EN
        // 2: minute adjust wraps without carrying into hours; run=0 holds seconds
        do_reset(1'b0);
        pulse_min(59);
        check("t2_min59", min_bcd, 8'h59);
        check("t2_hour", hour_bcd, 8'h00);
        check("t2_sec_hold", sec_bcd, 8'h00);
        pulse_min(1);
        check("t2_min00", min_bcd, 8'h00);
        check("t2_hour_nc", hour_bcd, 8'h00);
        check("t2_no_wrap", 8'(n_mw), 8'd0);

        // 3: 23:59:59 rolls to 00:00:00
        do_reset(1'b0);
        pulse_hour(23);
        pulse_min(59);
        run = 1'b1;
        step(4 * 59);
        check("t3_pre_h", hour_bcd, 8'h23);
        check("t3_pre_m", min_bcd, 8'h59);
        check("t3_pre_s", sec_bcd, 8'h59);
        n_mw = 0;
        step(4);
        check("t3_hour", hour_bcd, 8'h00);
        check("t3_min", min_bcd, 8'h00);
        check("t3_sec", sec_bcd, 8'h00);
        check("t3_wrap", 8'(n_mw), 8'd1);

        // 4: clear edge lands on the tick at :37
        do_reset(1'b1);
        step(4 * 37);
        check("t4_pre", sec_bcd, 8'h37);
        n_sp = 0;
        step(1);
        sec_clr = 1'b1;
        step(3);
        check("t4_clr", sec_bcd, 8'h00);
        check("t4_no_pulse", 8'(n_sp), 8'd0);
        sec_clr = 1'b0;
        step(3);
        check("t4_hold", sec_bcd, 8'h00);
        step(1);
        check("t4_restart", sec_bcd, 8'h01);
        check("t4_pulse", 8'(n_sp), 8'd1);

        // 5: minute adjust coincident with the 59:59 tick
        do_reset(1'b0);
        pulse_min(59);
        run = 1'b1;
        step(4 * 59);
        check("t5_pre_s", sec_bcd, 8'h59);
        step(1);
        min_adv = 1'b1;
        step(3);
        check("t5_min", min_bcd, 8'h01);
        check("t5_hour", hour_bcd, 8'h01);
        check("t5_sec", sec_bcd, 8'h00);
        min_adv = 1'b0;
        step(6);

        // reset mid-count returns everything immediately
        @(posedge selfClk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_sec", sec_bcd, 8'h00);
        check("rst_mid_min", min_bcd, 8'h00);
        check("rst_mid_hour", hour_bcd, 8'h00);
        step(1);
        reset = 1'b0;
        step(4);
        check("rst_mid_after", sec_bcd, 8'h01);
`else
        // 6: 12-hour mode, pm toggles at 11->12 only
        do_reset(1'b0);
        check("t6_rst_hour", hour_bcd, 8'h12);
        pulse_hour(11);
        check("t6_h11", hour_bcd, 8'h11);
        check("t6_pm0", {7'd0, pm}, 8'h00);
        pulse_min(59);
        run = 1'b1;
        step(4 * 59);
        step(4);
        check("t6_h12", hour_bcd, 8'h12);
        check("t6_m00", min_bcd, 8'h00);
        check("t6_s00", sec_bcd, 8'h00);
        check("t6_pm1", {7'd0, pm}, 8'h01);
        run = 1'b0;
        pulse_min(59);
        run = 1'b1;
        step(4 * 59);
        check("t6_pre", min_bcd, 8'h59);
        step(4);
        check("t6_h01", hour_bcd, 8'h01);
        check("t6_pm_keep", {7'd0, pm}, 8'h01);
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
